// File: rtl/kernel_control_sync_if.sv
// Host/engine control bundle for kernel_control_sync.
// Ports (signals):
//   ap_start, ap_continue, setup_done           host/setup side requests
//   channel_enable, channel_done [NUM_CHANNELS] engine channel selection and done
//   ap_ready, ap_done, ap_idle, start, setup    handshake/status outputs
//   state_onehot [7], busy_cycles [COUNTER_WIDTH] FSM state and BUSY length of last run
// Modports: master drives the requests (host side), slave is the sequencer.
interface kernel_control_sync_if #(
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned COUNTER_WIDTH = 32
);
    localparam int unsigned ST_W = 7;

    logic                     ap_start;
    logic                     ap_continue;
    logic                     setup_done;
    logic [NUM_CHANNELS-1:0]  channel_enable;
    logic [NUM_CHANNELS-1:0]  channel_done;
    logic                     ap_ready;
    logic                     ap_done;
    logic                     ap_idle;
    logic                     start;
    logic                     setup;
    logic [ST_W-1:0]          state_onehot;
    logic [COUNTER_WIDTH-1:0] busy_cycles;

    modport master (
        output ap_start, ap_continue, setup_done, channel_enable, channel_done,
        input  ap_ready, ap_done, ap_idle, start, setup, state_onehot, busy_cycles
    );

    modport slave (
        input  ap_start, ap_continue, setup_done, channel_enable, channel_done,
        output ap_ready, ap_done, ap_idle, start, setup, state_onehot, busy_cycles
    );
endinterface

// File: rtl/kernel_control_sync.sv
// Kernel control sequencer: IDLE -> SETUP -> READY -> START -> BUSY -> DONE,
// aggregating done from NUM_CHANNELS engine channels. The DONE exit rule is
// chosen at elaboration by CTRL_MODE (0 USER_MANAGED, 1 AP_CTRL_HS, 2 AP_CTRL_CHAIN).
// Ports:
//   ap_clk    kernel clock, rising edge
//   ap_rst_n  asynchronous active-low reset
//   ctrl      kernel_control_sync_if.slave (host requests, channel enable/done,
//             ap_* status, start/setup strobes, state_onehot, busy_cycles)
// Optional feature: define KERNEL_CONTROL_SYNC_BUSY_COUNTER_EN to build the
// saturating BUSY cycle counter; otherwise busy_cycles is tied to zero.
module kernel_control_sync #(
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned CTRL_MODE     = 2,
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    kernel_control_sync_if.slave  ctrl
);
    localparam int unsigned ST_W  = 7;
    localparam int unsigned NCH   = NUM_CHANNELS;
    localparam int unsigned CW    = COUNTER_WIDTH;

    localparam int unsigned B_IDLE  = 1;
    localparam int unsigned B_SETUP = 2;
    localparam int unsigned B_READY = 3;
    localparam int unsigned B_START = 4;
    localparam int unsigned B_DONE  = 6;

    typedef enum logic [ST_W-1:0] {
        S_RESET = 7'b0000001,
        S_IDLE  = 7'b0000010,
        S_SETUP = 7'b0000100,
        S_READY = 7'b0001000,
        S_START = 7'b0010000,
        S_BUSY  = 7'b0100000,
        S_DONE  = 7'b1000000
    } state_e;

    // Elaboration-time parameter checks.
    if (CTRL_MODE > 2) begin : g_bad_mode
        $error("kernel_control_sync: CTRL_MODE must be 0, 1 or 2");
    end
    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 32) begin : g_bad_nch
        $error("kernel_control_sync: NUM_CHANNELS must be 1..32");
    end

    // Plain vector so any corrupted (non one-hot) value is representable and recoverable.
    logic [ST_W-1:0] state_q, state_d;
    logic [NCH-1:0]  enable_q, enable_d;
    logic [NCH-1:0]  sticky_q, sticky_d;
    logic [NCH-1:0]  seen_c;
    logic            done_exit_c;

    // DONE exit condition per handshake mode.
    if (CTRL_MODE == 0) begin : g_user
        logic unused_cont_c;
        assign unused_cont_c = ctrl.ap_continue;
        assign done_exit_c   = ~ctrl.ap_start;
    end else if (CTRL_MODE == 1) begin : g_hs
        logic unused_cont_c;
        assign unused_cont_c = ctrl.ap_continue;
        assign done_exit_c   = 1'b1;
    end else begin : g_chain
        assign done_exit_c   = ctrl.ap_continue;
    end

    // Next-state logic; illegal encodings fall back to RESET.
    always_comb begin
        state_d  = state_q;
        enable_d = enable_q;
        sticky_d = sticky_q;
        seen_c   = sticky_q | (ctrl.channel_done & enable_q);
        case (state_q)
            S_RESET: state_d = S_IDLE;
            S_IDLE:  if (ctrl.ap_start)   state_d = S_SETUP;
            S_SETUP: if (ctrl.setup_done) state_d = S_READY;
            S_READY: state_d = S_START;
            S_START: begin
                enable_d = ctrl.channel_enable;
                sticky_d = '0;
                state_d  = S_BUSY;
            end
            S_BUSY: begin
                sticky_d = seen_c;
                if (seen_c == enable_q) state_d = S_DONE;
            end
            S_DONE:  if (done_exit_c) state_d = S_IDLE;
            default: state_d = S_RESET;
        endcase
    end

    // State, channel enable and sticky done registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= S_RESET;
            enable_q <= '0;
            sticky_q <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            sticky_q <= sticky_d;
        end
    end

    // Status strobes are single bits of the one-hot state register.
    assign ctrl.state_onehot = state_q;
    assign ctrl.ap_idle      = state_q[B_IDLE];
    assign ctrl.setup        = state_q[B_SETUP];
    assign ctrl.ap_ready     = state_q[B_READY];
    assign ctrl.start        = state_q[B_START];
    assign ctrl.ap_done      = state_q[B_DONE];

`ifdef KERNEL_CONTROL_SYNC_BUSY_COUNTER_EN
    logic [CW-1:0] cnt_q, cnt_d, busy_q, busy_d, cnt_inc_c;

    // Saturating increment: holds at all-ones instead of wrapping.
    assign cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    // Counter clears in START, counts BUSY cycles; result latched on entry to DONE.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (state_q == S_START) begin
            cnt_d = '0;
        end else if (state_q == S_BUSY) begin
            cnt_d = cnt_inc_c;
            if (state_d == S_DONE) busy_d = cnt_inc_c;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_q  <= '0;
            busy_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign ctrl.busy_cycles = busy_q;
`else
    assign ctrl.busy_cycles = CW'(0);
`endif

endmodule

// File: tb/tb_kernel_control_sync.sv
// Bench for kernel_control_sync: one instance per handshake mode sharing the
// same stimulus, each compared every cycle against a phase/remaining-set model.
module tb_kernel_control_sync;
    localparam int unsigned NCH = 4;
    localparam int unsigned NI  = 3;   // 0 USER_MANAGED, 1 HS (4-bit counter), 2 CHAIN

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ap_start, ap_continue, setup_done;
    logic [3:0] ch_en, ch_dn;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    kernel_control_sync_if #(.NUM_CHANNELS(NCH), .COUNTER_WIDTH(32)) if_user ();
    kernel_control_sync_if #(.NUM_CHANNELS(NCH), .COUNTER_WIDTH(4))  if_hs ();
    kernel_control_sync_if #(.NUM_CHANNELS(NCH), .COUNTER_WIDTH(32)) if_chain ();

    kernel_control_sync #(.NUM_CHANNELS(NCH), .CTRL_MODE(0), .COUNTER_WIDTH(32))
        u_user  (.ap_clk(clk), .ap_rst_n(rst_n), .ctrl(if_user));
    kernel_control_sync #(.NUM_CHANNELS(NCH), .CTRL_MODE(1), .COUNTER_WIDTH(4))
        u_hs    (.ap_clk(clk), .ap_rst_n(rst_n), .ctrl(if_hs));
    kernel_control_sync #(.NUM_CHANNELS(NCH), .CTRL_MODE(2), .COUNTER_WIDTH(32))
        u_chain (.ap_clk(clk), .ap_rst_n(rst_n), .ctrl(if_chain));

    assign if_user.ap_start        = ap_start;
    assign if_user.ap_continue     = ap_continue;
    assign if_user.setup_done      = setup_done;
    assign if_user.channel_enable  = ch_en;
    assign if_user.channel_done    = ch_dn;
    assign if_hs.ap_start          = ap_start;
    assign if_hs.ap_continue       = ap_continue;
    assign if_hs.setup_done        = setup_done;
    assign if_hs.channel_enable    = ch_en;
    assign if_hs.channel_done      = ch_dn;
    assign if_chain.ap_start       = ap_start;
    assign if_chain.ap_continue    = ap_continue;
    assign if_chain.setup_done     = setup_done;
    assign if_chain.channel_enable = ch_en;
    assign if_chain.channel_done   = ch_dn;

    // Observed outputs: dec = {ap_idle, setup, ap_ready, start, ap_done}
    logic [6:0]  act_st  [NI];
    logic [4:0]  act_dec [NI];
    logic [31:0] act_bc  [NI];
    assign act_st[0]  = if_user.state_onehot;
    assign act_st[1]  = if_hs.state_onehot;
    assign act_st[2]  = if_chain.state_onehot;
    assign act_dec[0] = {if_user.ap_idle, if_user.setup, if_user.ap_ready, if_user.start, if_user.ap_done};
    assign act_dec[1] = {if_hs.ap_idle, if_hs.setup, if_hs.ap_ready, if_hs.start, if_hs.ap_done};
    assign act_dec[2] = {if_chain.ap_idle, if_chain.setup, if_chain.ap_ready, if_chain.start, if_chain.ap_done};
    assign act_bc[0]  = if_user.busy_cycles;
    assign act_bc[1]  = 32'(if_hs.busy_cycles);
    assign act_bc[2]  = if_chain.busy_cycles;

    // Reference model: phase number is the one-hot bit index of the state.
    localparam int P_RESET = 0, P_IDLE = 1, P_SETUP = 2, P_READY = 3,
                   P_START = 4, P_BUSY = 5, P_DONE = 6;
    int         ph      [NI];
    logic [3:0] remain  [NI];   // enabled channels not yet seen done
    longint     cnt     [NI];
    longint     last_bc [NI];
    bit         illegal [NI];
    int         mode    [NI] = '{0, 1, 2};
    longint     maxc    [NI] = '{64'hFFFF_FFFF, 64'd15, 64'hFFFF_FFFF};

    function automatic void model_step(int i);
        if (!rst_n) begin
            ph[i] = P_RESET; last_bc[i] = 0; illegal[i] = 0;
            return;
        end
        if (illegal[i]) begin
            ph[i] = P_RESET; illegal[i] = 0;
            return;
        end
        case (ph[i])
            P_RESET: ph[i] = P_IDLE;
            P_IDLE:  if (ap_start)   ph[i] = P_SETUP;
            P_SETUP: if (setup_done) ph[i] = P_READY;
            P_READY: ph[i] = P_START;
            P_START: begin remain[i] = ch_en; cnt[i] = 0; ph[i] = P_BUSY; end
            P_BUSY: begin
                cnt[i]    = cnt[i] + 1;
                remain[i] = remain[i] & ~ch_dn;
                if (remain[i] == 4'd0) begin
                    ph[i]      = P_DONE;
                    last_bc[i] = (cnt[i] > maxc[i]) ? maxc[i] : cnt[i];
                end
            end
            default: begin
                if ((mode[i] == 0 && !ap_start) || mode[i] == 1 || (mode[i] == 2 && ap_continue))
                    ph[i] = P_IDLE;
            end
        endcase
    endfunction

    function automatic logic [31:0] exp_bc(int i);
`ifdef KERNEL_CONTROL_SYNC_BUSY_COUNTER_EN
        return 32'(last_bc[i]);
`else
        return 32'd0 & 32'(last_bc[i]);
`endif
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [6:0] es;
        logic [4:0] ed;
        for (int i = 0; i < NI; i++) begin
            es = 7'(1 << ph[i]);
            ed = {ph[i] == P_IDLE, ph[i] == P_SETUP, ph[i] == P_READY, ph[i] == P_START, ph[i] == P_DONE};
            cmp($sformatf("model_state%0d", i), 32'(act_st[i]), 32'(es));
            cmp($sformatf("model_dec%0d", i), 32'(act_dec[i]), 32'(ed));
            cmp($sformatf("model_busy%0d", i), act_bc[i], exp_bc(i));
        end
    endtask

    // One clock: models advance on the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_step(i);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b0; setup_done = 1'b0;
        ch_en = 4'd0; ch_dn = 4'd0;
        step(); step();
        cmp("reset_state", 32'(act_st[2]), 32'h01);
        cmp("reset_dec", 32'(act_dec[1]), 32'h00);
        cmp("reset_busy", act_bc[0], 32'd0);
        rst_n = 1'b1;
        step();
        cmp("reset_to_idle", 32'(act_st[0]), 32'h02);
    endtask

    typedef struct {
        logic       st;
        logic       sd;
        logic [3:0] en;
        logic [3:0] dn;
        logic       cont;
        logic [6:0] exp;   // CHAIN state after the clock
    } vec_t;
    vec_t tbl [18];

    function automatic vec_t mk(logic st, logic sd, logic [3:0] dn, logic cont, logic [6:0] exp);
        vec_t v;
        v.st = st; v.sd = sd; v.en = 4'hF; v.dn = dn; v.cont = cont; v.exp = exp;
        return v;
    endfunction

    initial begin
        #400000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int dcnt;
        for (int i = 0; i < NI; i++) begin
            ph[i] = P_RESET; remain[i] = 4'd0; cnt[i] = 0; last_bc[i] = 0; illegal[i] = 0;
        end

        // CHAIN run: done on ch0 at BUSY cycle 2, ch1/ch2 at 5, ch3 at 9; continue in 3rd DONE cycle.
        tbl[0]  = mk(1, 1, 4'h0, 0, 7'h04);
        tbl[1]  = mk(0, 1, 4'h0, 0, 7'h08);
        tbl[2]  = mk(0, 1, 4'h0, 0, 7'h10);
        tbl[3]  = mk(0, 1, 4'h0, 0, 7'h20);
        tbl[4]  = mk(0, 1, 4'h0, 0, 7'h20);
        tbl[5]  = mk(0, 1, 4'h0, 0, 7'h20);
        tbl[6]  = mk(0, 1, 4'h1, 0, 7'h20);
        tbl[7]  = mk(0, 1, 4'h0, 0, 7'h20);
        tbl[8]  = mk(0, 1, 4'h0, 0, 7'h20);
        tbl[9]  = mk(0, 1, 4'h6, 0, 7'h20);
        tbl[10] = mk(0, 1, 4'h0, 0, 7'h20);
        tbl[11] = mk(0, 1, 4'h0, 0, 7'h20);
        tbl[12] = mk(0, 1, 4'h0, 0, 7'h20);
        tbl[13] = mk(0, 1, 4'h8, 0, 7'h40);
        tbl[14] = mk(0, 1, 4'h0, 0, 7'h40);
        tbl[15] = mk(0, 1, 4'h0, 0, 7'h40);
        tbl[16] = mk(0, 1, 4'h0, 1, 7'h02);
        tbl[17] = mk(0, 1, 4'h0, 0, 7'h02);

        do_reset();
        for (int k = 0; k < 18; k++) begin
            ap_start = tbl[k].st; setup_done = tbl[k].sd; ch_en = tbl[k].en;
            ch_dn = tbl[k].dn; ap_continue = tbl[k].cont;
            step();
            cmp($sformatf("chain_tbl%0d", k), 32'(act_st[2]), 32'(tbl[k].exp));
        end
`ifdef KERNEL_CONTROL_SYNC_BUSY_COUNTER_EN
        cmp("chain_busy_cycles", act_bc[2], 32'd10);
`else
        cmp("chain_busy_cycles", act_bc[2], 32'd0);
`endif

        // HS: only disabled channels report done -> stuck in BUSY until ch0+ch2.
        do_reset();
        ap_start = 1; setup_done = 1; ch_en = 4'b0101; ch_dn = 4'b1010;
        step(); ap_start = 0;
        step(); step(); step();
        repeat (8) step();
        cmp("hs_stuck_busy", 32'(act_st[1]), 32'h20);
        ch_dn = 4'b0101; step();
        cmp("hs_done", 32'(act_dec[1]), 32'h01);
        ch_dn = 4'b1010; step();
        cmp("hs_idle", 32'(act_st[1]), 32'h02);

        // No channels enabled: exactly one BUSY cycle.
        do_reset();
        ap_start = 1; setup_done = 1; ch_en = 4'b0000; ch_dn = 4'b0000;
        step(); ap_start = 0;
        step(); step(); step();
        cmp("en0_busy", 32'(act_st[1]), 32'h20);
        step();
        cmp("en0_done", 32'(act_st[1]), 32'h40);
`ifdef KERNEL_CONTROL_SYNC_BUSY_COUNTER_EN
        cmp("en0_busy_cycles", act_bc[1], 32'd1);
`else
        cmp("en0_busy_cycles", act_bc[1], 32'd0);
`endif

        // USER_MANAGED: ap_done held while ap_start=1, ap_continue ignored.
        do_reset();
        ap_start = 1; setup_done = 1; ch_en = 4'hF; ch_dn = 4'hF;
        repeat (5) step();
        dcnt = 0;
        for (int k = 0; k < 5; k++) begin
            dcnt += int'(act_dec[0][0]);
            ap_continue = ~ap_continue;
            if (k == 4) ap_start = 0;
            step();
        end
        cmp("user_done_len", 32'(dcnt), 32'd5);
        cmp("user_idle", 32'(act_st[0]), 32'h02);
        ap_continue = 0;

        // Asynchronous reset in the middle of BUSY.
        do_reset();
        ap_start = 1; setup_done = 1; ch_en = 4'hF; ch_dn = 4'h0;
        step(); ap_start = 0;
        repeat (5) step();
        cmp("pre_arst_busy", 32'(act_st[2]), 32'h20);
        #2 rst_n = 0;
        #1;
        cmp("arst_state", 32'(act_st[2]), 32'h01);
        cmp("arst_nodone", 32'(act_dec[2]), 32'h00);
        step();
        cmp("arst_hold_nodone", 32'(act_dec[0] | act_dec[1] | act_dec[2]), 32'h00);
        rst_n = 1;
        step();
        cmp("arst_release_idle", 32'(act_st[2]), 32'h02);

        // Corrupted (two-hot) state recovers through RESET.
        do_reset();
        force u_chain.state_q = 7'b0000011;
        #1 release u_chain.state_q;
        illegal[2] = 1;
        step();
        cmp("illegal_to_reset", 32'(act_st[2]), 32'h01);
        step();
        cmp("illegal_recover", 32'(act_st[2]), 32'h02);

        // Saturation of the 4-bit counter on the HS instance.
        do_reset();
        ap_start = 1; setup_done = 1; ch_en = 4'b0101; ch_dn = 4'h0;
        step(); ap_start = 0;
        step(); step(); step();
        repeat (19) step();
        ch_dn = 4'b0101; step();
        ch_dn = 4'h0;
        cmp("sat_done", 32'(act_st[1]), 32'h40);
`ifdef KERNEL_CONTROL_SYNC_BUSY_COUNTER_EN
        cmp("sat_busy_cycles", act_bc[1], 32'hF);
`else
        cmp("sat_busy_cycles", act_bc[1], 32'h0);
`endif

        // Random traffic against the model, with occasional resets.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            ap_start    = ($urandom_range(0, 2) != 0);
            setup_done  = ($urandom_range(0, 2) == 0);
            ch_en       = 4'($urandom);
            ch_dn       = 4'($urandom) & 4'($urandom);
            ap_continue = ($urandom_range(0, 3) == 0);
            rst_n       = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
